icache: RTL and testbench
=========================

# icache

Direct-mapped, read-only instruction cache between the fetcher and the memory controller. It is the responder end of the fetch request interface: it accepts a PC request and returns a 32-bit instruction word. On a miss it refills a whole block from the memory controller, one word at a time. A flush input from the reorder buffer drops any pending reply on a mispredict.

## Interface
- ADDR_WIDTH, 32, address width.
- BLOCK_WIDTH, 1, log2 of words per block (BLOCK_SIZE = 2 words = 8 bytes).
- CACHE_WIDTH, 8, log2 of block count (256 lines); index = addr[CACHE_WIDTH+BLOCK_WIDTH+1 : BLOCK_WIDTH+2].
- Tag = addr[ADDR_WIDTH-1 : CACHE_WIDTH+BLOCK_WIDTH+2]; word offset = addr[BLOCK_WIDTH+1:2]; addr[1:0] ignored.

Ports:
- clk_in  in  1  clock; all state on posedge.
- rst_in  in  1  synchronous, active-high reset.
- rdy_in  in  1  global enable; when 0, all state and outputs hold.
- IF2IC_en  in  1  fetch request, held high while requesting.
- IF2IC_addr  in  ADDR_WIDTH  fetch PC.
- IC2IF_en  out  1  one-cycle reply strobe.
- IC2IF_data  out  32  instruction word, valid when IC2IF_en=1.
- RoB2IC_flush  in  1  mispredict; cancels reply for the current request.
- IC2MC_en  out  1  word read request to memory controller, held during refill.
- IC2MC_addr  out  ADDR_WIDTH  word-aligned address of the word being requested.
- MC2IC_en  in  1  one-cycle strobe: MC2IC_data holds the word at IC2MC_addr.
- MC2IC_data  in  32  returned word.

## Operation
- Storage: per line a valid bit, a tag, and BLOCK_SIZE 32-bit words. Arrays are read combinationally; outputs are registered.
- States: IDLE, REFILL.
- IDLE, request accepted when rdy_in && IF2IC_en && !IC2IF_en && !RoB2IC_flush:
  - hit (valid && tag match): next cycle IC2IF_en=1, IC2IF_data = line word[offset].
  - miss: go to REFILL; word counter=0; latch the block base {tag,index,0}; IC2MC_en=1; IC2MC_addr=base.
- Reply gap: while IC2IF_en=1, no new request is accepted. The fetcher updates its PC on the reply cycle, so back-to-back hits return one word every 2 cycles.
- REFILL:
  - On each MC2IC_en, write MC2IC_data into line word[counter]; counter++; IC2MC_addr += 4 on the same edge.
  - After the last word (counter == BLOCK_SIZE-1 when MC2IC_en): write the tag, set valid, IC2MC_en=0, return to IDLE.
  - The request is then re-looked-up and hits; no reply is issued directly from REFILL.
- Flush:
  - In IDLE, RoB2IC_flush blocks acceptance that cycle.
  - In REFILL, the flush is ignored; the refill completes and fills the line. Any reply afterwards depends only on the request present when IDLE is re-entered.
- IC2IF_en is cleared every cycle it is not set by a hit.
- Cache contents are never invalidated except by reset; no write path.

## Timing
- Reset values: IC2IF_en=0, IC2IF_data=0, IC2MC_en=0, IC2MC_addr=0, state=IDLE, counter=0, all valid bits=0.
- Hit latency: request visible in cycle t -> IC2IF_en=1 in cycle t+1.
- Miss latency: request in cycle t -> IC2MC_en=1 in t+1. Last MC2IC_en in cycle m -> IDLE in m+1 -> IC2IF_en in m+2.
- IC2MC_en stays high through the whole refill. Each MC2IC_en consumes exactly the address currently on IC2MC_addr.
- MC2IC_en in IDLE is ignored.
- rdy_in=0 mid-refill: counter, address, and state freeze. MC2IC_en in that cycle is ignored; the memory controller must re-present the word.
- rst_in mid-refill: return to IDLE and drop IC2MC_en next cycle; all lines are invalid.
- Request address changing during REFILL: the refill still fills the latched block. The lookup on return uses the new address.

## Test plan
- Cold miss at 0x0000_0000, memory returns 0x00000013 and 0x00100093:
  - IC2MC_addr goes 0x0 then 0x4; IC2MC_en drops.
  - IC2IF_data=0x00000013 two cycles after the last MC2IC_en.
- Hit after fill, request 0x4 -> IC2IF_en one cycle later with 0x00100093; no IC2MC_en.
- Held request: IF2IC_en held high at the same address -> replies on alternate cycles only (1,0,1,0 pattern).
- Conflict: 0x0000_0000 then 0x0000_0800 (same index, different tag) -> second request misses and refills; a re-request of 0x0 misses again.
- Flush during refill at 0x10:
  - Refill completes; the line is valid.
  - With IF2IC_en low on return to IDLE, no IC2IF_en pulse is issued.
- rdy_in low for 3 cycles between refill words -> IC2MC_addr held; final data is correct.
- Reset asserted mid-refill -> all outputs return to reset values next cycle; the next request to the same address misses.

Source files
------------

// File: rtl/icache_if.sv
// ---------------------------------------------------------------------------
// icache_if
//   Fetch-side and memory-side bus of the instruction cache, bundled so the
//   cache and its environment connect through one port.
//
//   Fetch side : IF2IC_en / IF2IC_addr  (request, held while requesting)
//                IC2IF_en / IC2IF_data  (one-cycle reply strobe + word)
//                RoB2IC_flush           (mispredict, blocks acceptance)
//   Memory side: IC2MC_en / IC2MC_addr  (word read request, held in refill)
//                MC2IC_en / MC2IC_data  (one-cycle returned word strobe)
//
//   modport slave  : the cache's view
//   modport master : the fetcher / memory controller / testbench view
// ---------------------------------------------------------------------------
interface icache_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  IF2IC_en;
  logic [ADDR_WIDTH-1:0] IF2IC_addr;
  logic                  IC2IF_en;
  logic [31:0]           IC2IF_data;
  logic                  RoB2IC_flush;
  logic                  IC2MC_en;
  logic [ADDR_WIDTH-1:0] IC2MC_addr;
  logic                  MC2IC_en;
  logic [31:0]           MC2IC_data;

  modport slave (
    input  IF2IC_en, IF2IC_addr, RoB2IC_flush, MC2IC_en, MC2IC_data,
    output IC2IF_en, IC2IF_data, IC2MC_en, IC2MC_addr
  );

  modport master (
    output IF2IC_en, IF2IC_addr, RoB2IC_flush, MC2IC_en, MC2IC_data,
    input  IC2IF_en, IC2IF_data, IC2MC_en, IC2MC_addr
  );
endinterface

// File: rtl/icache.sv
// ---------------------------------------------------------------------------
// icache
//   Direct-mapped, read-only instruction cache. A fetch request that hits is
//   answered with a one-cycle reply strobe the next cycle; a miss refills the
//   whole block from the memory controller one word at a time, after which
//   the (still held) request is looked up again and hits.
//
//   Ports:
//     clk_in  : clock, all state on the rising edge
//     rst_in  : synchronous active-high reset
//     rdy_in  : global enable; when low every register holds
//     bus     : icache_if.slave (fetch request/reply, flush, memory bus)
//
//   Address split: | tag | index (CACHE_WIDTH) | word (BLOCK_WIDTH) | 2'b00 |
// ---------------------------------------------------------------------------
module icache #(
  parameter int ADDR_WIDTH  = 32,
  parameter int BLOCK_WIDTH = 1,
  parameter int CACHE_WIDTH = 8
) (
  input  logic     clk_in,
  input  logic     rst_in,
  input  logic     rdy_in,
  icache_if.slave  bus
);

  localparam int BLOCK_SIZE = 1 << BLOCK_WIDTH;
  localparam int CACHE_SIZE = 1 << CACHE_WIDTH;
  localparam int OFF_LO     = 2;
  localparam int IDX_LO     = BLOCK_WIDTH + 2;
  localparam int TAG_LO     = CACHE_WIDTH + BLOCK_WIDTH + 2;
  localparam int TAG_WIDTH  = ADDR_WIDTH - TAG_LO;

  typedef enum logic {
    IDLE,
    REFILL
  } state_t;

  // Registered state and outputs
  state_t                 r_state;
  logic [BLOCK_WIDTH-1:0] r_cnt;
  logic                   r_if_en;
  logic [31:0]            r_if_data;
  logic                   r_mc_en;
  logic [ADDR_WIDTH-1:0]  r_mc_addr;

  // Line storage
  logic [CACHE_SIZE-1:0]  r_valid;
  logic [TAG_WIDTH-1:0]   r_tag  [CACHE_SIZE];
  logic [31:0]            r_data [CACHE_SIZE][BLOCK_SIZE];

  // Next-state values
  state_t                 w_state_nx;
  logic [BLOCK_WIDTH-1:0] w_cnt_nx;
  logic                   w_if_en_nx;
  logic [31:0]            w_if_data_nx;
  logic                   w_mc_en_nx;
  logic [ADDR_WIDTH-1:0]  w_mc_addr_nx;
  logic                   w_word_wr;
  logic                   w_line_done;

  // Request address fields
  logic [TAG_WIDTH-1:0]   w_req_tag;
  logic [CACHE_WIDTH-1:0] w_req_idx;
  logic [BLOCK_WIDTH-1:0] w_req_off;
  logic                   w_hit;
  logic                   w_accept;

  // Refill target: the block being filled is identified by the address
  // currently on the memory bus, so no separate latch is needed.
  logic [TAG_WIDTH-1:0]   w_fill_tag;
  logic [CACHE_WIDTH-1:0] w_fill_idx;

  // Byte-offset bits of the PC carry no information for word fetches.
  logic                   w_unused_addr_lsb;

  assign w_req_tag  = bus.IF2IC_addr[ADDR_WIDTH-1:TAG_LO];
  assign w_req_idx  = bus.IF2IC_addr[TAG_LO-1:IDX_LO];
  assign w_req_off  = bus.IF2IC_addr[IDX_LO-1:OFF_LO];
  assign w_fill_tag = r_mc_addr[ADDR_WIDTH-1:TAG_LO];
  assign w_fill_idx = r_mc_addr[TAG_LO-1:IDX_LO];
  assign w_unused_addr_lsb = ^bus.IF2IC_addr[1:0];

  assign w_hit = r_valid[w_req_idx] && (r_tag[w_req_idx] == w_req_tag);

  // While a reply is on the bus the fetcher is still updating its PC, so the
  // request seen that cycle is stale and must not be accepted.
  assign w_accept = bus.IF2IC_en && !r_if_en && !bus.RoB2IC_flush;

  // -------------------------------------------------------------------------
  // Next-state / output logic
  // -------------------------------------------------------------------------
  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nx   = r_state;
    w_cnt_nx     = r_cnt;
    w_if_en_nx   = 1'b0;
    w_if_data_nx = r_if_data;
    w_mc_en_nx   = r_mc_en;
    w_mc_addr_nx = r_mc_addr;
    w_word_wr    = 1'b0;
    w_line_done  = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_hit) begin
            w_if_en_nx   = 1'b1;
            w_if_data_nx = r_data[w_req_idx][w_req_off];
          end else begin
            w_state_nx   = REFILL;
            w_cnt_nx     = '0;
            w_mc_en_nx   = 1'b1;
            w_mc_addr_nx = {w_req_tag, w_req_idx, {(BLOCK_WIDTH + 2){1'b0}}};
          end
        end
      end

      REFILL: begin
        // Flush is deliberately ignored here: finishing the fill leaves a
        // valid line, and the request is re-evaluated once back in IDLE.
        if (bus.MC2IC_en) begin
          w_word_wr    = 1'b1;
          w_cnt_nx     = r_cnt + BLOCK_WIDTH'(1);
          w_mc_addr_nx = r_mc_addr + ADDR_WIDTH'(4);
          if (r_cnt == BLOCK_WIDTH'(BLOCK_SIZE - 1)) begin
            w_line_done = 1'b1;
            w_mc_en_nx  = 1'b0;
            w_state_nx  = IDLE;
          end
        end
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State, outputs and valid bits
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_if_en   <= 1'b0;
      r_if_data <= '0;
      r_mc_en   <= 1'b0;
      r_mc_addr <= '0;
      r_valid   <= '0;
    end else if (rdy_in) begin
      r_state   <= w_state_nx;
      r_cnt     <= w_cnt_nx;
      r_if_en   <= w_if_en_nx;
      r_if_data <= w_if_data_nx;
      r_mc_en   <= w_mc_en_nx;
      r_mc_addr <= w_mc_addr_nx;
      if (w_line_done) begin
        r_valid[w_fill_idx] <= 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Tag and data arrays
  // -------------------------------------------------------------------------
  // NOTE: tag and data arrays are not reset; the valid bits alone decide
  // whether their contents are meaningful, which keeps them plain RAM.
  always_ff @(posedge clk_in) begin
    if (!rst_in && rdy_in && w_word_wr) begin
      r_data[w_fill_idx][r_cnt] <= bus.MC2IC_data;
      if (w_line_done) begin
        r_tag[w_fill_idx] <= w_fill_tag;
      end
    end
  end

  assign bus.IC2IF_en   = r_if_en;
  assign bus.IC2IF_data = r_if_data;
  assign bus.IC2MC_en   = r_mc_en;
  assign bus.IC2MC_addr = r_mc_addr;

endmodule

// File: tb/tb_icache.sv
// ---------------------------------------------------------------------------
// tb_icache
//   Directed bench for icache: a table of fetches with hand-computed replies,
//   followed by hand-written sequences for held requests, flush, rdy_in
//   stalls and reset in the middle of a refill. The memory controller is
//   played by the bench; word contents come from mem_word().
// ---------------------------------------------------------------------------
module tb_icache;

  localparam int AW = 32;

  logic clk_in = 1'b0;
  logic rst_in;
  logic rdy_in;

  icache_if #(.ADDR_WIDTH(AW)) bus ();

  icache #(
    .ADDR_WIDTH (AW),
    .BLOCK_WIDTH(1),
    .CACHE_WIDTH(8)
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .rdy_in(rdy_in),
    .bus   (bus)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    bit          miss;
  } vec_t;

  vec_t vecs [10];

  // Memory image served by the bench.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0000)      return 32'h0000_0013;
    else if (a == 32'h0000_0004) return 32'h0010_0093;
    else                         return 32'hDEAD_0000 | {16'h0000, a[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Advance one cycle; outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Serve a whole two-word block starting at base, one word per cycle.
  task automatic serve_refill(input logic [31:0] base, input string name);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s mc_addr[%0d]", name, i), bus.IC2MC_addr,
            base + 32'(4 * i));
      check($sformatf("%s mc_en[%0d]", name, i), 32'(bus.IC2MC_en), 32'd1);
      bus.MC2IC_en   = 1'b1;
      bus.MC2IC_data = mem_word(base + 32'(4 * i));
      tick();
      bus.MC2IC_en   = 1'b0;
      bus.MC2IC_data = 32'h0;
    end
    check({name, " mc_en dropped"}, 32'(bus.IC2MC_en), 32'd0);
    check({name, " no reply from refill"}, 32'(bus.IC2IF_en), 32'd0);
  endtask

  // Issue one fetch and hold it until the reply, then release it.
  task automatic fetch(input logic [31:0] addr, input logic [31:0] exp_data,
                       input bit exp_miss, input string name);
    bus.IF2IC_en   = 1'b1;
    bus.IF2IC_addr = addr;
    tick();
    if (exp_miss) begin
      check({name, " miss mc_en"}, 32'(bus.IC2MC_en), 32'd1);
      check({name, " miss no reply"}, 32'(bus.IC2IF_en), 32'd0);
      serve_refill(addr & 32'hFFFF_FFF8, name);
      tick();
    end else begin
      check({name, " hit no mc_en"}, 32'(bus.IC2MC_en), 32'd0);
    end
    check({name, " reply en"}, 32'(bus.IC2IF_en), 32'd1);
    check({name, " reply data"}, bus.IC2IF_data, exp_data);
    bus.IF2IC_en = 1'b0;
    tick();
    check({name, " reply cleared"}, 32'(bus.IC2IF_en), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "tb_icache timeout");
  end

  initial begin
    vecs[0] = '{addr: 32'h0000_0000, data: 32'h0000_0013, miss: 1'b1};
    vecs[1] = '{addr: 32'h0000_0004, data: 32'h0010_0093, miss: 1'b0};
    vecs[2] = '{addr: 32'h0000_0000, data: 32'h0000_0013, miss: 1'b0};
    vecs[3] = '{addr: 32'h0000_0800, data: 32'hDEAD_0800, miss: 1'b1};
    vecs[4] = '{addr: 32'h0000_0804, data: 32'hDEAD_0804, miss: 1'b0};
    vecs[5] = '{addr: 32'h0000_0000, data: 32'h0000_0013, miss: 1'b1};
    vecs[6] = '{addr: 32'h0000_002C, data: 32'hDEAD_002C, miss: 1'b1};
    vecs[7] = '{addr: 32'h0000_002B, data: 32'hDEAD_0028, miss: 1'b0};
    vecs[8] = '{addr: 32'hFFFF_FFFC, data: 32'hDEAD_FFFC, miss: 1'b1};
    vecs[9] = '{addr: 32'hFFFF_FFF8, data: 32'hDEAD_FFF8, miss: 1'b0};

    rst_in           = 1'b1;
    rdy_in           = 1'b1;
    bus.IF2IC_en     = 1'b0;
    bus.IF2IC_addr   = 32'h0;
    bus.RoB2IC_flush = 1'b0;
    bus.MC2IC_en     = 1'b0;
    bus.MC2IC_data   = 32'h0;
    tick();
    tick();
    check("reset if_en",   32'(bus.IC2IF_en), 32'd0);
    check("reset if_data", bus.IC2IF_data,    32'h0);
    check("reset mc_en",   32'(bus.IC2MC_en), 32'd0);
    check("reset mc_addr", bus.IC2MC_addr,    32'h0);
    rst_in = 1'b0;
    tick();

    // Table: cold miss, hits, conflict eviction, ignored byte bits, top line.
    for (int i = 0; i < 10; i++) begin
      fetch(vecs[i].addr, vecs[i].data, vecs[i].miss, $sformatf("vec%0d", i));
    end

    // Memory strobe while idle must not disturb anything.
    bus.MC2IC_en   = 1'b1;
    bus.MC2IC_data = 32'hBAD0_BAD0;
    tick();
    bus.MC2IC_en   = 1'b0;
    check("idle mc strobe mc_en", 32'(bus.IC2MC_en), 32'd0);
    check("idle mc strobe if_en", 32'(bus.IC2IF_en), 32'd0);
    fetch(32'h0000_0000, 32'h0000_0013, 1'b0, "after idle strobe");

    // Held request: replies on alternate cycles.
    bus.IF2IC_en   = 1'b1;
    bus.IF2IC_addr = 32'h0000_0004;
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("held if_en[%0d]", i), 32'(bus.IC2IF_en),
            (i % 2 == 0) ? 32'd1 : 32'd0);
      if (i % 2 == 0)
        check($sformatf("held data[%0d]", i), bus.IC2IF_data, 32'h0010_0093);
    end
    bus.IF2IC_en = 1'b0;
    tick();
    check("held released", 32'(bus.IC2IF_en), 32'd0);

    // Flush in IDLE blocks acceptance for that cycle only.
    bus.IF2IC_en     = 1'b1;
    bus.IF2IC_addr   = 32'h0000_0004;
    bus.RoB2IC_flush = 1'b1;
    tick();
    check("idle flush blocks", 32'(bus.IC2IF_en), 32'd0);
    bus.RoB2IC_flush = 1'b0;
    tick();
    check("after flush reply", 32'(bus.IC2IF_en), 32'd1);
    check("after flush data", bus.IC2IF_data, 32'h0010_0093);
    bus.IF2IC_en = 1'b0;
    tick();

    // Flush during refill at 0x10: fill completes, no reply afterwards.
    bus.IF2IC_en   = 1'b1;
    bus.IF2IC_addr = 32'h0000_0010;
    tick();
    check("flush refill mc_en", 32'(bus.IC2MC_en), 32'd1);
    bus.RoB2IC_flush = 1'b1;
    bus.IF2IC_en     = 1'b0;
    serve_refill(32'h0000_0010, "flush refill");
    bus.RoB2IC_flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("flush no reply[%0d]", i), 32'(bus.IC2IF_en), 32'd0);
    end
    fetch(32'h0000_0010, 32'hDEAD_0010, 1'b0, "flushed line valid");

    // rdy_in low for 3 cycles between refill words of block 0x30.
    bus.IF2IC_en   = 1'b1;
    bus.IF2IC_addr = 32'h0000_0030;
    tick();
    check("stall mc_addr0", bus.IC2MC_addr, 32'h0000_0030);
    bus.MC2IC_en   = 1'b1;
    bus.MC2IC_data = mem_word(32'h0000_0030);
    tick();
    rdy_in         = 1'b0;
    bus.MC2IC_data = 32'hBAD0_BAD0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("stall mc_addr hold[%0d]", i), bus.IC2MC_addr,
            32'h0000_0034);
      check($sformatf("stall mc_en hold[%0d]", i), 32'(bus.IC2MC_en), 32'd1);
    end
    rdy_in         = 1'b1;
    bus.MC2IC_data = mem_word(32'h0000_0034);
    tick();
    bus.MC2IC_en   = 1'b0;
    bus.MC2IC_data = 32'h0;
    check("stall mc_en dropped", 32'(bus.IC2MC_en), 32'd0);
    tick();
    check("stall reply en", 32'(bus.IC2IF_en), 32'd1);
    check("stall reply data", bus.IC2IF_data, 32'hDEAD_0030);
    bus.IF2IC_en = 1'b0;
    tick();
    fetch(32'h0000_0034, 32'hDEAD_0034, 1'b0, "stall second word");

    // Reset in the middle of a refill at 0x40.
    bus.IF2IC_en   = 1'b1;
    bus.IF2IC_addr = 32'h0000_0040;
    tick();
    check("rst refill mc_en", 32'(bus.IC2MC_en), 32'd1);
    bus.MC2IC_en   = 1'b1;
    bus.MC2IC_data = mem_word(32'h0000_0040);
    tick();
    bus.MC2IC_en   = 1'b0;
    check("rst refill mc_addr", bus.IC2MC_addr, 32'h0000_0044);
    rst_in       = 1'b1;
    bus.IF2IC_en = 1'b0;
    tick();
    check("mid rst if_en",   32'(bus.IC2IF_en), 32'd0);
    check("mid rst if_data", bus.IC2IF_data,    32'h0);
    check("mid rst mc_en",   32'(bus.IC2MC_en), 32'd0);
    check("mid rst mc_addr", bus.IC2MC_addr,    32'h0);
    rst_in = 1'b0;
    tick();
    fetch(32'h0000_0040, 32'hDEAD_0040, 1'b1, "post rst 0x40");
    fetch(32'h0000_0004, 32'h0010_0093, 1'b1, "post rst 0x4");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
